// File: rtl/imem_responder.sv
`default_nettype none
// imem_responder: word-array instruction ROM with a valid/ready fetch port
// and a byte-stream program loader that owns the array while fetch is blocked.
module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD    = 32'h0000_0013
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [31:0]                   req_addr,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [31:0]                   resp_data,
    output logic                          resp_fault,
    input  logic                          load_en,
    input  logic                          load_byte_valid,
    input  logic [7:0]                    load_byte,
    output logic                          load_active,
    output logic [$clog2(DEPTH_WORDS):0]  load_words,
    output logic                          load_overflow
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RESP  = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [1:0]    byte_cnt;
    logic [23:0]   asm_word;
    logic [29:0]   word_off;
    logic          fault;
    logic [AW-1:0] rd_idx;
    logic          accept;
    logic          full;
    logic          take_byte;
    logic [1:0]    cnt_after;
    logic          enter_load;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [31:0]   wr_data;

    // BASE_ADDR is word aligned, so the word offset is a 30-bit wrapping subtract.
    assign word_off  = req_addr[31:2] - BASE_ADDR[31:2];
    assign fault     = (req_addr[1:0] != 2'b00) || ({2'b00, word_off} >= 32'(DEPTH_WORDS));
    assign rd_idx    = word_off[AW-1:0];
    assign accept    = req_valid && req_ready;
    assign full      = (load_words == (AW+1)'(DEPTH_WORDS));
    assign take_byte = (state == S_LOAD) && load_byte_valid && !full;
    assign cnt_after = byte_cnt + 2'(take_byte);
    assign enter_load = (state_next == S_LOAD) && (state != S_LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (load_en)     state_next = S_LOAD;
                else if (accept) state_next = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    if (accept)       state_next = S_RESP;
                    else if (load_en) state_next = S_LOAD;
                    else              state_next = S_IDLE;
                end
            end
            S_LOAD: begin
                // A byte landing on the same edge counts toward the pending partial word.
                if (!load_en) state_next = (cnt_after == 2'd0) ? S_IDLE : S_FLUSH;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready   = !load_en && ((state == S_IDLE) || ((state == S_RESP) && resp_ready));
        resp_valid  = (state == S_RESP);
        load_active = (state == S_LOAD) || (state == S_FLUSH);
    end

    always_comb begin
        wr_en   = (take_byte && (byte_cnt == 2'd3)) || ((state == S_FLUSH) && !full);
        wr_idx  = load_words[AW-1:0];
        wr_data = (state == S_FLUSH) ? {8'h00, asm_word} : {load_byte, asm_word};
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_data     <= NOP_WORD;
            resp_fault    <= 1'b0;
            load_words    <= '0;
            load_overflow <= 1'b0;
            byte_cnt      <= 2'd0;
            asm_word      <= 24'h0;
        end else begin
            if (accept) begin
                resp_fault <= fault;
                resp_data  <= fault ? NOP_WORD : mem[rd_idx];
            end
            if (enter_load) begin
                load_words    <= '0;
                load_overflow <= 1'b0;
                byte_cnt      <= 2'd0;
                asm_word      <= 24'h0;
            end else if ((state == S_LOAD) && load_byte_valid) begin
                if (full) begin
                    load_overflow <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        load_words <= load_words + 1'b1;
                        asm_word   <= 24'h0;
                    end else begin
                        asm_word[{byte_cnt, 3'b000} +: 8] <= load_byte;
                    end
                end
            end else if (state == S_FLUSH) begin
                if (!full) load_words <= load_words + 1'b1;
                byte_cnt <= 2'd0;
                asm_word <= 24'h0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder that serves the fetch stage's ROM requests. Accepts word-aligned fetch addresses over a valid/ready request channel and returns the instruction word one cycle later over a valid/ready response channel, from an on-chip word array. It also owns a byte-stream program loader that writes the array while fetch is blocked. Sits between the instruction-fetch stage and the program download path.

## Interface
- DEPTH_WORDS, 1024, array depth in 32-bit words (power of two, ≥ 4)
- BASE_ADDR, 32'h0000_0000, byte address of word 0
- NOP_WORD, 32'h0000_0013, data returned on fault and after reset
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  fetch request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_addr  in  32  fetch byte address
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumed when resp_valid && resp_ready
- resp_data  out  32  instruction word
- resp_fault  out  1  request was misaligned or out of range
- load_en  in  1  loader session request (level)
- load_byte_valid  in  1  load_byte valid this cycle
- load_byte  in  8  program byte, little-endian order
- load_active  out  1  high while in LOAD or FLUSH
- load_words  out  clog2(DEPTH_WORDS)+1  words written in current/last session
- load_overflow  out  1  sticky: bytes arrived after array full in this session

## Operation
- States: IDLE, RESP, LOAD, FLUSH.
- Decode: offset = req_addr − BASE_ADDR (32-bit wrap); fault if req_addr[1:0] ≠ 0 or offset[31:2] ≥ DEPTH_WORDS. Fault response: resp_data = NOP_WORD, resp_fault = 1, array not read.
- req_ready = !load_en && (state == IDLE || (state == RESP && resp_ready)).
- IDLE: accepted request → RESP. load_en high → LOAD (load wins over a same-cycle req_valid; request not accepted).
- RESP: resp_valid = 1, resp_data/resp_fault held stable until consumed. On consume: new accepted request → stay RESP with new data; else load_en → LOAD; else IDLE.
- LOAD: on session entry load_words = 0, byte counter = 0, load_overflow = 0. Each load_byte_valid places the byte into lane byte_cnt of an assembly word; on 4th byte the word is written at index load_words on that same edge and load_words increments. When load_words == DEPTH_WORDS, further bytes are discarded and load_overflow set. load_byte_valid ignored outside LOAD.
- load_en low in LOAD: byte_cnt == 0 → IDLE; else → FLUSH.
- FLUSH (one cycle): write partial word, unfilled upper lanes zero, increment load_words (unless full) → IDLE.
- Array contents are not reset; reset mid-load leaves already written words intact and returns to IDLE.

## Timing
- Reset values: state IDLE, resp_valid 0, resp_data NOP_WORD, resp_fault 0, load_active 0, load_words 0, load_overflow 0; req_ready = !load_en.
- Read latency 1: request accepted at edge N → resp_valid high after edge N, data from array state at edge N.
- Throughput 1 word/cycle while resp_ready held high and load_en low.
- Write-then-fetch: word written at edge N is returned by a request accepted at edge ≥ N+1.
- Loader: load_active rises the cycle after load_en is sampled in IDLE (or on RESP consume); falls after last LOAD/FLUSH edge.
- Backpressure: resp_ready low holds resp_valid/resp_data/resp_fault unchanged and req_ready low.

## Test plan
- Reset, then load 8 bytes 13 00 00 00 93 00 10 00 → load_words = 2; fetch 0x0 then 0x4 with resp_ready=1 back-to-back → resp_data 0x00000013, 0x00100093 on consecutive cycles, resp_fault 0.
- Fetch 0x2 and 4·DEPTH_WORDS → resp_fault 1, resp_data 0x00000013 each.
- Load 6 bytes AA BB CC DD 11 22, drop load_en → FLUSH writes 0x00002211 at word 1, load_words = 2.
- Hold resp_ready low 3 cycles during a response → outputs stable, req_ready 0; raise → consumed, next request accepted same edge.
- load_en and req_valid asserted same cycle in IDLE → request not accepted, LOAD entered; load 4·DEPTH_WORDS+1 bytes → load_overflow 1, load_words = DEPTH_WORDS.
- Assert rst_n low mid-load after 5 bytes → all outputs return to reset values; fetch 0x0 returns the word written before reset.
